tx_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares one UART transmit path between up to NUM_REQ byte-stream requesters. It grants one requester at a time, forwards that requester's bytes into the TX FIFO until the frame's last byte, then waits for the transmitter to drain and inserts a programmable inter-frame gap measured in baud ticks. It sits between the requester logic and the TX FIFO/TX core, and observes the TX core's one-hot state and baud pulse.

---
 rtl/tx_pkg.sv | 36 +++
 rtl/tx_frame_arbiter_rr_pick.sv | 40 ++++
 rtl/tx_frame_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the UART transmit-side arbiter:
//   - arbiter FSM one-hot state encoding
//   - TX core one-hot state constants (as observed on tx_state_i)
//   - default configuration constants
//   - round-robin index wrap helper
// ---------------------------------------------------------------------------
package tx_pkg;

    // Arbiter states, one-hot
    typedef enum logic [3:0] {
        ARB_IDLE  = 4'b0001,
        ARB_XFER  = 4'b0010,
        ARB_DRAIN = 4'b0100,
        ARB_GAP   = 4'b1000
    } arb_state_e;

    // TX core states, one-hot; INTERVAL means the line is idle between frames
    localparam logic [4:0] TX_INTERVAL = 5'b0_0001;
    localparam logic [4:0] TX_STARTBIT = 5'b0_0010;
    localparam logic [4:0] TX_DATABITS = 5'b0_0100;
    localparam logic [4:0] TX_PARITY   = 5'b0_1000;
    localparam logic [4:0] TX_STOPBIT  = 5'b1_0000;

    // Default configuration
    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_GAP_W         = 4;
    localparam int DEF_TIMEOUT_TICKS = 16;

    // Index of the requester 'off' positions after 'base', wrapping at n
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection. The search starts at the
// requester after 'last' and wraps, so the most recently served requester
// has the lowest priority.
// Ports:
//   req    in  N   request vector
//   last   in  IW  index of the previously granted requester
//   onehot out N   one-hot winner (0 when no request)
//   idx    out IW  winner index (0 when no request)
//   any    out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import tx_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // off = N lands back on 'last' itself, so a lone requester always wins
        for (int off = 1; off <= N; off++) begin
            if (!any && req[IW'(rr_wrap(int'(last), off, N))]) begin
                any                                     = 1'b1;
                onehot[IW'(rr_wrap(int'(last), off, N))] = 1'b1;
                idx                                     = IW'(rr_wrap(int'(last), off, N));
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tx_frame_arbiter
// Frame-level round-robin arbiter sharing one UART TX path between NUM_REQ
// byte-stream requesters. A granted requester streams bytes into the TX FIFO
// until its last byte; the arbiter then waits for the FIFO to empty and the
// TX core to reach INTERVAL, and inserts gap_cfg_i baud ticks of idle line
// before the next grant.
//
// Optional feature macro: TX_ARB_TIMEOUT_EN
//   defined   - a granted requester that stays silent for TIMEOUT_TICKS baud
//               ticks is dropped (abort_o pulse, normal drain/gap follows)
//   undefined - XFER waits indefinitely, abort_o is tied low
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   req_valid_i    per-requester byte valid
//   req_data_i     per-requester byte, requester k at [8k+7:8k]
//   req_last_i     per-requester last-byte-of-frame flag
//   req_ready_o    per-requester byte accepted this cycle
//   fifo_full_i    TX FIFO full
//   fifo_empty_i   TX FIFO empty
//   fifo_wr_o      TX FIFO write strobe
//   fifo_data_o    TX FIFO write data
//   tx_state_i     TX core one-hot state
//   p_BaudSig_i    one-clock baud pulse
//   gap_cfg_i      inter-frame gap in baud ticks, 0 = none
//   grant_o        one-hot current grant, 0 when none
//   busy_o         arbiter not idle
//   frame_done_o   one-clock pulse when a frame slot completes
//   abort_o        one-clock pulse on stall timeout
// ---------------------------------------------------------------------------
module tx_frame_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int GAP_W         = DEF_GAP_W,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 fifo_full_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_wr_o,
    output logic [7:0]           fifo_data_o,
    input  logic [4:0]           tx_state_i,
    input  logic                 p_BaudSig_i,
    input  logic [GAP_W-1:0]     gap_cfg_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 abort_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("tx_frame_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("tx_frame_arbiter: TIMEOUT_TICKS must be >= 1");
    end

    arb_state_e             state, state_nxt;
    logic [NUM_REQ-1:0]     grant, grant_nxt;
    logic [IDX_W-1:0]       gidx, gidx_nxt;
    logic [IDX_W-1:0]       last, last_nxt;
    logic [GAP_W-1:0]       gap_cnt, gap_nxt;
    logic                   done, done_nxt;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    logic [NUM_REQ-1:0][7:0] data_arr;
    logic                   vld_g;
    logic                   last_g;
    logic                   accept;
    logic                   tx_idle;
    logic                   timeout_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req    (req_valid_i),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign data_arr = req_data_i;
    assign vld_g    = req_valid_i[gidx];
    assign last_g   = req_last_i[gidx];
    assign accept   = (state == ARB_XFER) && vld_g && !fifo_full_i;
    // Transmitter has nothing queued and the line is between frames
    assign tx_idle  = fifo_empty_i && (tx_state_i == TX_INTERVAL);

    // Datapath: bytes flow straight through from the granted requester
    assign fifo_wr_o    = accept;
    assign req_ready_o  = grant & {NUM_REQ{accept}};
    assign fifo_data_o  = data_arr[gidx];
    assign grant_o      = grant;
    assign busy_o       = (state != ARB_IDLE);
    assign frame_done_o = done;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_TICKS + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               abort_q;

    // Only silence from the requester counts; FIFO backpressure does not
    assign timeout_hit = (state == ARB_XFER) && !vld_g && p_BaudSig_i &&
                         (stall_cnt == STALL_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
            if (state != ARB_XFER || accept || timeout_hit)
                stall_cnt <= '0;
            else if (!vld_g && p_BaudSig_i)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign abort_o = abort_q;
`else
    assign timeout_hit = 1'b0;
    assign abort_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            gidx    <= '0;
            last    <= IDX_W'(NUM_REQ - 1);
            gap_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            gidx    <= gidx_nxt;
            last    <= last_nxt;
            gap_cnt <= gap_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        last_nxt  = last;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_oh;
                    gidx_nxt  = pick_idx;
                    last_nxt  = pick_idx;
                    state_nxt = ARB_XFER;
                end
            end

            ARB_XFER: begin
                if (accept && last_g) begin
                    grant_nxt = '0;
                    state_nxt = ARB_DRAIN;
                end else if (timeout_hit) begin
                    grant_nxt = '0;
                    state_nxt = ARB_DRAIN;
                end
            end

            ARB_DRAIN: begin
                if (tx_idle) begin
                    if (gap_cfg_i == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = ARB_IDLE;
                    end else begin
                        // Gap length is latched here; later edits don't
                        // affect the gap already in progress
                        gap_nxt   = gap_cfg_i;
                        state_nxt = ARB_GAP;
                    end
                end
            end

            ARB_GAP: begin
                if (p_BaudSig_i) begin
                    // <= 1 also covers a zero count so GAP can never stick
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ARB_IDLE;
                    end else begin
                        gap_nxt = gap_cnt - 1'b1;
                    end
                end
            end

            default: begin
                grant_nxt = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;
    import tx_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full  = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           fifo_wr;
    logic [7:0]     fifo_data;
    logic [4:0]     tx_state = TX_INTERVAL;
    logic           baud     = 1'b0;
    logic [3:0]     gap_cfg  = '0;
    logic [N-1:0]   grant;
    logic           busy, frame_done, abort;

    always #5 clk = ~clk;

    tx_frame_arbiter #(
        .NUM_REQ       (N),
        .GAP_W         (4),
        .TIMEOUT_TICKS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .fifo_wr_o    (fifo_wr),
        .fifo_data_o  (fifo_data),
        .tx_state_i   (tx_state),
        .p_BaudSig_i  (baud),
        .gap_cfg_i    (gap_cfg),
        .grant_o      (grant),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .abort_o      (abort)
    );

    // Requester byte stores: {last, data}
    logic [8:0]  rmem [N][32];
    int          rhead [N];
    int          rtail [N];
    // Scoreboard: {requester index, data} in expected write order
    logic [15:0] expq [$];

    int n_chk = 0, n_pass = 0;
    int wr_cnt = 0, done_cnt = 0, abort_cnt = 0;
    logic         s_wr, s_busy, s_done, s_abort;
    logic [N-1:0] s_grant, s_ready, acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (rhead[k] != rtail[k]);
            {req_last[k], req_data[8*k +: 8]} = rmem[k][rhead[k] % 32];
        end
    endtask

    task automatic load(input int k, input int nbytes, input logic [7:0] base, input bit last_flag);
        for (int j = 0; j < nbytes; j++) begin
            rmem[k][rtail[k] % 32] = {last_flag && (j == nbytes - 1), base + 8'(j)};
            rtail[k]++;
            expq.push_back({8'(k), base + 8'(j)});
        end
        drive();
    endtask

    // Sample at negedge, score writes, then advance past next posedge
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        s_wr = fifo_wr; s_busy = busy; s_done = frame_done; s_abort = abort;
        s_grant = grant; s_ready = req_ready;
        if (fifo_wr) begin
            wr_cnt++;
            chk("wr_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("wr_data", 32'(fifo_data), 32'(e[7:0]));
                chk("wr_grant", 32'(grant), 32'd1 << e[15:8]);
                chk("wr_ready", 32'(req_ready), 32'(grant));
            end
        end
        done_cnt  += int'(frame_done);
        abort_cnt += int'(abort);
        acc = rst ? req_ready : '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (acc[k]) rhead[k]++;
        drive();
    endtask

    task automatic wait_wr(input int target, input string tag);
        for (int i = 0; i < 300 && wr_cnt < target; i++) tick();
        chk(tag, 32'(wr_cnt >= target), 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 300 && (done_cnt < target || expq.size() != 0); i++) tick();
        chk(tag, 32'(done_cnt >= target && expq.size() == 0), 1);
    endtask

    task automatic pulse();
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, d0;
        for (int k = 0; k < N; k++) begin rhead[k] = 0; rtail[k] = 0; end
        drive();

        // Reset state
        repeat (2) tick();
        chk("rst_grant", 32'(s_grant), 0);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_wr", 32'(s_wr), 0);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_abort", 32'(s_abort), 0);
        rst = 1'b1;
        tick();

        // All four request 3-byte frames: served 0,1,2,3
        w0 = wr_cnt; d0 = done_cnt;
        for (int k = 0; k < N; k++) load(k, 3, 8'(16 * (k + 1)), 1'b1);
        wait_done(d0 + 4, "rr4_done");
        chk("rr4_writes", 32'(wr_cnt - w0), 12);
        chk("rr4_frames", 32'(done_cnt - d0), 4);
        tick();
        chk("rr4_idle", 32'(s_busy), 0);

        // Requester 2 alone, FIFO full for 5 clocks mid-frame
        w0 = wr_cnt; d0 = done_cnt;
        load(2, 2, 8'hA0, 1'b1);
        wait_wr(w0 + 1, "full_first_byte");
        fifo_full = 1'b1;
        repeat (5) begin
            tick();
            chk("full_no_wr", 32'(s_wr), 0);
            chk("full_no_ready", 32'(s_ready), 0);
            chk("full_grant_held", 32'(s_grant), 32'b0100);
        end
        fifo_full = 1'b0;
        wait_done(d0 + 1, "full_done");
        chk("full_writes", 32'(wr_cnt - w0), 2);

        // Gap of 3 baud ticks, drain held off by a busy transmitter
        w0 = wr_cnt; d0 = done_cnt;
        tx_state = TX_STARTBIT;
        gap_cfg  = 4'd3;
        load(1, 2, 8'h50, 1'b1);
        wait_wr(w0 + 2, "gap_bytes");
        repeat (4) begin
            tick();
            chk("drain_busy", 32'(s_busy), 1);
            chk("drain_no_done", 32'(s_done), 0);
            chk("drain_grant", 32'(s_grant), 0);
        end
        tx_state = TX_INTERVAL;
        tick();
        gap_cfg = 4'd7;
        tick();
        chk("gap_quiet_done", 32'(s_done), 0);
        for (int i = 1; i <= 3; i++) begin
            pulse();
            chk("gap_done_on_3rd", 32'(s_done), 32'(i == 3));
        end
        tick();
        chk("gap_idle", 32'(s_busy), 0);
        chk("gap_frames", 32'(done_cnt - d0), 1);
        gap_cfg = 4'd0;

        // Zero gap: done on first cycle with empty & INTERVAL, next grant 1 clk later
        w0 = wr_cnt; d0 = done_cnt;
        tx_state   = TX_STARTBIT;
        fifo_empty = 1'b0;
        load(3, 1, 8'hC0, 1'b1);
        load(0, 1, 8'hD0, 1'b1);
        wait_wr(w0 + 1, "g0_first");
        fifo_empty = 1'b1;
        repeat (2) begin tick(); chk("g0_startbit_hold", 32'(s_done), 0); end
        fifo_empty = 1'b0;
        tx_state   = TX_INTERVAL;
        repeat (2) begin tick(); chk("g0_notempty_hold", 32'(s_done), 0); end
        fifo_empty = 1'b1;
        tick();
        tick();
        chk("g0_done", 32'(s_done), 1);
        chk("g0_done_grant", 32'(s_grant), 0);
        tick();
        chk("g0_next_grant", 32'(s_grant), 32'b0001);
        chk("g0_done_pulse", 32'(s_done), 0);
        wait_done(d0 + 2, "g0_frames");

        // Requester 1 goes silent after one byte
        w0 = wr_cnt; d0 = done_cnt;
        load(1, 1, 8'h70, 1'b0);
        wait_wr(w0 + 1, "to_first");
`ifdef TX_ARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            pulse();
            chk("to_abort", 32'(s_abort), 32'(i == 16));
            if (i == 15) chk("to_grant_before", 32'(s_grant), 32'b0010);
        end
        chk("to_grant_dropped", 32'(s_grant), 0);
        wait_done(d0 + 1, "to_drain");
        chk("to_abort_count", 32'(abort_cnt), 1);
`else
        repeat (100) pulse();
        chk("noto_grant_held", 32'(s_grant), 32'b0010);
        chk("noto_busy", 32'(s_busy), 1);
        chk("noto_abort_count", 32'(abort_cnt), 0);
        load(1, 1, 8'h71, 1'b1);
        wait_done(d0 + 1, "noto_done");
`endif

        // Reset after 1 of 4 bytes
        w0 = wr_cnt;
        load(2, 4, 8'h80, 1'b1);
        wait_wr(w0 + 1, "rst_first");
        rst = 1'b0;
        expq.delete();
        for (int k = 0; k < N; k++) rhead[k] = rtail[k];
        drive();
        tick();
        chk("mid_rst_grant", 32'(s_grant), 0);
        chk("mid_rst_busy", 32'(s_busy), 0);
        chk("mid_rst_wr", 32'(s_wr), 0);
        chk("mid_rst_ready", 32'(s_ready), 0);
        chk("mid_rst_done", 32'(s_done), 0);
        chk("mid_rst_abort", 32'(s_abort), 0);
        rst = 1'b1;
        tick();
        d0 = done_cnt;
        load(0, 2, 8'hE0, 1'b1);
        load(1, 2, 8'h90, 1'b1);
        wait_done(d0 + 2, "post_rst_frames");
        tick();
        chk("final_idle", 32'(s_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
